// File: rtl/lpc_pkg.sv
// Shared types and constants for the LPC host-side request scheduler.
package lpc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_GUARD = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } lpc_state_e;

    localparam logic [7:0] IDLE_RDATA    = 8'h00;
    localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

endpackage

// File: rtl/lpc_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer moves on accept.
module lpc_rr_arb2 (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    // Index of the requester granted last; reset to 1 so requester 0 wins the first tie.
    logic last_q;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            last_q <= 1'b1;
        end else if (accept_i && (gnt_o != 2'b00)) begin
            last_q <= gnt_o[1];
        end
    end

endmodule

// File: rtl/lpc_host_sched.sv
// Schedules I/O read/write requests from two requesters onto a single LPC host port.
module lpc_host_sched
    import lpc_pkg::*;
#(
    parameter int LFRAME_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic [1:0]  req_i,
    input  logic [1:0]  we_i,
    input  logic [31:0] addr_i,
    input  logic [15:0] wdata_i,
    output logic [1:0]  ack_o,
    output logic        err_o,
    output logic [7:0]  rdata_o,
    output logic [15:0] host_addr_o,
    output logic [7:0]  host_wdata_o,
    output logic        host_lframe_o,
    output logic        host_rd_o,
    output logic        host_wr_o,
    input  logic        host_ready_i,
    input  logic [7:0]  host_rdata_i,
    output logic        busy_o
);

    // Handshake: req_i[n] is a level request held until ack_o[n] pulses for one cycle;
    // err_o/rdata_o are valid only with that pulse, and requests are not sampled
    // during the ack cycle, so a request still high one cycle later is a new one.

    localparam logic [1:0] LF_LAST = 2'(LFRAME_CYCLES - 1);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    lpc_state_e  state_q;
    logic [1:0]  lf_cnt_q;
    logic [7:0]  tmo_q;
    logic [1:0]  gnt_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic        lframe_q;
    logic        rd_q;
    logic        wr_q;
    logic [1:0]  ack_q;
    logic        err_q;
    logic [7:0]  rdata_q;
    logic [7:0]  cap_rdata_q;
    logic        cap_err_q;

    logic [1:0]  arb_gnt;
    logic        grant_go;
    logic        sel_we;
    logic [15:0] sel_addr;
    logic [7:0]  sel_wdata;

    assign grant_go  = (state_q == ST_IDLE) && (ack_q == 2'b00) && (req_i != 2'b00) && host_ready_i;
    assign sel_we    = arb_gnt[1] ? we_i[1]         : we_i[0];
    assign sel_addr  = arb_gnt[1] ? addr_i[31:16]   : addr_i[15:0];
    assign sel_wdata = arb_gnt[1] ? wdata_i[15:8]   : wdata_i[7:0];

    lpc_rr_arb2 u_arb (
        .clk_i    (clk_i),
        .nrst_i   (nrst_i),
        .req_i    (req_i),
        .accept_i (grant_go),
        .gnt_o    (arb_gnt)
    );

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q     <= ST_IDLE;
            lf_cnt_q    <= 2'd0;
            tmo_q       <= 8'd0;
            gnt_q       <= 2'b00;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            lframe_q    <= 1'b1;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            ack_q       <= 2'b00;
            err_q       <= 1'b0;
            rdata_q     <= IDLE_RDATA;
            cap_rdata_q <= IDLE_RDATA;
            cap_err_q   <= 1'b0;
        end else begin
            ack_q   <= 2'b00;
            err_q   <= 1'b0;
            rdata_q <= IDLE_RDATA;
            case (state_q)
                ST_IDLE: begin
                    if (grant_go) begin
                        gnt_q    <= arb_gnt;
                        addr_q   <= sel_addr;
                        wdata_q  <= sel_wdata;
                        wr_q     <= sel_we;
                        rd_q     <= ~sel_we;
                        lframe_q <= 1'b0;
                        lf_cnt_q <= 2'd0;
                        state_q  <= ST_START;
                    end
                end
                ST_START: begin
                    if (lf_cnt_q == LF_LAST) begin
                        lframe_q <= 1'b1;
                        state_q  <= ST_GUARD;
                    end else begin
                        lf_cnt_q <= lf_cnt_q + 2'd1;
                    end
                end
                ST_GUARD: begin
                    tmo_q   <= 8'd0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (host_ready_i) begin
                        cap_rdata_q <= wr_q ? IDLE_RDATA : host_rdata_i;
                        cap_err_q   <= 1'b0;
                        state_q     <= ST_DONE;
                    end else if (tmo_q == TO_LAST) begin
                        cap_rdata_q <= TIMEOUT_RDATA;
                        cap_err_q   <= 1'b1;
                        state_q     <= ST_DONE;
                    end else if (tmo_q != 8'hFF) begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    ack_q   <= gnt_q;
                    err_q   <= cap_err_q;
                    rdata_q <= cap_rdata_q;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ack_o         = ack_q;
    assign err_o         = err_q;
    assign rdata_o       = rdata_q;
    assign host_addr_o   = addr_q;
    assign host_wdata_o  = wdata_q;
    assign host_lframe_o = lframe_q;
    assign host_rd_o     = rd_q;
    assign host_wr_o     = wr_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: doc/lpc_host_sched.md
LPC_HOST_SCHED -- requirements
Module: lpc_host_sched

Interface
REQ-001 Parameter LFRAME_CYCLES, default 2: number of clk_i cycles host_lframe_o is held low per transaction (legal range 1..4).
REQ-002 Parameter TIMEOUT_CYCLES, default 64: maximum WAIT cycles before abort (legal range 2..255).
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low; ports clk_i and nrst_i.
REQ-004 clk_i  input  1  block clock, same clock as the LPC host control port.
REQ-005 nrst_i  input  1  asynchronous active-low reset.
REQ-006 req_i  input  2  per-requester request; bit n belongs to requester n.
REQ-007 we_i  input  2  per-requester direction: 1 = I/O write, 0 = I/O read.
REQ-008 addr_i  input  32  requester addresses: bits [16n+15:16n] belong to requester n.
REQ-009 wdata_i  input  16  requester write data: bits [8n+7:8n] belong to requester n.
REQ-010 ack_o  output  2  one-cycle completion pulse per requester.
REQ-011 err_o  output  1  timeout flag, valid only while any ack_o bit is high.
REQ-012 rdata_o  output  8  read data, valid only while any ack_o bit is high.
REQ-013 host_addr_o  output  16  address to the LPC host.
REQ-014 host_wdata_o  output  8  write data to the LPC host.
REQ-015 host_lframe_o  output  1  active-low frame start to the LPC host.
REQ-016 host_rd_o / host_wr_o  output  1 each  cycle-type flags to the LPC host.
REQ-017 host_ready_i  input  1  host idle/ready for the next cycle.
REQ-018 host_rdata_i  input  8  host read data.
REQ-019 busy_o  output  1  high in every state except IDLE.

Function
REQ-020 FSM states are IDLE, START, GUARD, WAIT, DONE.
REQ-021 IDLE: if any req_i bit is high and host_ready_i=1, grant one requester, latch its we/addr/wdata, and go to START next cycle; otherwise stay in IDLE.
REQ-022 Arbitration is round-robin: with both requests high, the requester not granted last wins; after reset requester 0 wins the first tie.
REQ-023 START: host_lframe_o=0 for exactly LFRAME_CYCLES cycles; host_rd_o=~we and host_wr_o=we for the latched request; then go to GUARD.
REQ-024 GUARD: one cycle in which host_ready_i is ignored; then go to WAIT.
REQ-025 WAIT: when host_ready_i=1, capture host_rdata_i (reads) and go to DONE with err=0; after TIMEOUT_CYCLES cycles in WAIT without ready, go to DONE with err=1 and rdata=8'hFF.
REQ-026 DONE: assert ack_o for the granted bit only, for one cycle, with err_o and rdata_o valid; rdata_o=8'h00 for writes; then return to IDLE.
REQ-027 host_addr_o, host_wdata_o, host_rd_o and host_wr_o hold the latched values from START through DONE; host_lframe_o=1 outside START.
REQ-028 Latency: a request granted in IDLE cycle T with immediate ready in WAIT yields ack_o at T+LFRAME_CYCLES+4.
REQ-029 A requester that drops req_i before grant is not served; dropping req_i after grant does not abort the transaction, and ack_o is still issued.
REQ-030 A requester that keeps req_i high in the cycle after ack_o is treated as a new request and is arbitrated normally.
REQ-031 The timeout counter is 8 bits, cleared on entry to WAIT, and saturates.

Reset
REQ-032 On nrst_i=0, regardless of state (including mid-transaction): state=IDLE, ack_o=0, err_o=0, rdata_o=0, host_addr_o=0, host_wdata_o=0, host_lframe_o=1, host_rd_o=0, host_wr_o=0, busy_o=0, round-robin pointer=1, counters=0.

Structure
REQ-033 The FSM state encoding and the constants IDLE_RDATA=8'h00 and TIMEOUT_RDATA=8'hFF belong in the shared package lpc_pkg.
REQ-034 The arbiter is one sub-module, lpc_rr_arb2: 2-bit request in, one-hot grant out, pointer update on an accept strobe.

Verification
REQ-035 Single write, req0, addr 16'hF0F0, data 8'h5A, ready returned after 10 cycles -> lframe low 2 cycles, host_wr_o=1, ack_o=2'b01, err_o=0.
REQ-036 Single read, req1, host_rdata_i=8'hA5 -> ack_o=2'b10, rdata_o=8'hA5, err_o=0.
REQ-037 Both requesters held high for 4 transactions -> grant order 0,1,0,1.
REQ-038 ready never returned -> ack after TIMEOUT_CYCLES in WAIT, err_o=1, rdata_o=8'hFF.
REQ-039 nrst_i pulsed low during WAIT -> all outputs at their reset values the same cycle; a following req0 read completes normally.
REQ-040 129 back-to-back write/read pairs, addr=i, wdata=i, host read data=8'hBB+i -> every ack carries the matching rdata and no ack is lost.
